twiddle_mult_2nd_ifft: RTL and testbench

Pipelined twiddle-factor complex multiplier for the second stage of the 64-point SDF mixed-radix IFFT. It sits directly downstream of the 2nd-stage twiddle index generator. Each cycle it takes one complex sample from the stage-2 butterfly output together with that row's twiddle index. It looks up the IFFT twiddle e^{+j2πm/64}, multiplies, rounds and saturates, then streams the result to stage 3 with a fixed 3-cycle latency and a frame-end marker.

---
 rtl/twiddle_mult_2nd_ifft.sv | 146 ++++++++++++++
 tb/tb_twiddle_mult_2nd_ifft.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_mult_2nd_ifft.sv
// Stage-2 IFFT twiddle multiplier: 3-stage pipeline (ROM lookup, products, round/saturate)
// with a 6-bit output frame counter that flags the last sample of each 64-point frame.
module twiddle_mult_2nd_ifft #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TW_W    = 16,
  parameter int unsigned TW_STEP = 8,
  parameter int unsigned NFFT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in_re,
  input  logic signed [DATA_W-1:0] data_in_im,
  input  logic [5:0]               Twiddle_address,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out_re,
  output logic signed [DATA_W-1:0] data_out_im,
  output logic                     frame_last
);

  localparam int unsigned PW = DATA_W + TW_W;  // full product width
  localparam int unsigned SW = PW + 1;         // full sum width
  localparam int unsigned SH = TW_W - 2;       // Q2.(TW_W-2) rescale
  localparam logic [5:0] TwStep  = 6'(TW_STEP);
  localparam logic [5:0] CntLast = 6'(NFFT - 1);
  localparam logic signed [SW-1:0] RndBias = SW'(64'd1 << (TW_W - 3));
  localparam logic signed [SW-1:0] SatMax  = SW'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic signed [SW-1:0] SatMin  = ~SatMax;

  // round(16384*cos(2*pi*k/64)) for k = 0..16
  function automatic logic signed [TW_W-1:0] quarter_cos(input logic [4:0] k);
    logic signed [TW_W-1:0] v;
    case (k)
      5'd0:    v = TW_W'(16384);
      5'd1:    v = TW_W'(16305);
      5'd2:    v = TW_W'(16069);
      5'd3:    v = TW_W'(15679);
      5'd4:    v = TW_W'(15137);
      5'd5:    v = TW_W'(14449);
      5'd6:    v = TW_W'(13623);
      5'd7:    v = TW_W'(12665);
      5'd8:    v = TW_W'(11585);
      5'd9:    v = TW_W'(10394);
      5'd10:   v = TW_W'(9102);
      5'd11:   v = TW_W'(7723);
      5'd12:   v = TW_W'(6270);
      5'd13:   v = TW_W'(4756);
      5'd14:   v = TW_W'(3196);
      5'd15:   v = TW_W'(1606);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Full-circle cosine from the quarter table by symmetry; no ties exist, so exact.
  function automatic logic signed [TW_W-1:0] tw_cos(input logic [5:0] m);
    logic signed [TW_W-1:0] v;
    if (m <= 6'd16)      v = quarter_cos(5'(m));
    else if (m <= 6'd32) v = -quarter_cos(5'(6'd32 - m));
    else if (m <= 6'd48) v = -quarter_cos(5'(m - 6'd32));
    else                 v = quarter_cos(5'(7'd64 - {1'b0, m}));
    return v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [DATA_W-1:0] v;
    if (x > SatMax)      v = SatMax[DATA_W-1:0];
    else if (x < SatMin) v = SatMin[DATA_W-1:0];
    else                 v = x[DATA_W-1:0];
    return v;
  endfunction

  logic [5:0]               w_m;
  logic signed [TW_W-1:0]   w_tw_re, w_tw_im;
  logic signed [SW-1:0]     w_sum_re, w_sum_im, w_shr_re, w_shr_im;
  logic signed [DATA_W-1:0] w_sat_re, w_sat_im;

  logic                     r_v1, r_v2, r_v3, r_last;
  logic [5:0]               r_cnt;
  logic signed [DATA_W-1:0] r_a_re, r_a_im;
  logic signed [TW_W-1:0]   r_w_re, r_w_im;
  logic signed [PW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [DATA_W-1:0] r_out_re, r_out_im;

  // Twiddle index scaling wraps modulo 64; sin(m) = cos(m - 16) with 6-bit wrap.
  always_comb begin
    w_m     = Twiddle_address * TwStep;
    w_tw_re = tw_cos(w_m);
    w_tw_im = tw_cos(w_m - 6'd16);
  end

  // S1/S2 datapath registers; contents are only meaningful under the matching valid bit.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_a_re <= data_in_re;
      r_a_im <= data_in_im;
      r_w_re <= w_tw_re;
      r_w_im <= w_tw_im;
    end
    if (r_v1) begin
      r_p_rr <= PW'(r_a_re) * PW'(r_w_re);
      r_p_ii <= PW'(r_a_im) * PW'(r_w_im);
      r_p_ri <= PW'(r_a_re) * PW'(r_w_im);
      r_p_ir <= PW'(r_a_im) * PW'(r_w_re);
    end
  end

  // S3 combine, round half toward +inf, then saturate.
  always_comb begin
    w_sum_re = SW'(r_p_rr) - SW'(r_p_ii);
    w_sum_im = SW'(r_p_ri) + SW'(r_p_ir);
    w_shr_re = (w_sum_re + RndBias) >>> SH;
    w_shr_im = (w_sum_im + RndBias) >>> SH;
    w_sat_re = sat(w_shr_re);
    w_sat_im = sat(w_shr_im);
  end

  // Valid pipeline, output registers and frame counter; outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      r_v1   <= valid_in;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_last <= r_v2 && (r_cnt == CntLast);
      if (r_v2) begin
        r_out_re <= w_sat_re;
        r_out_im <= w_sat_im;
        r_cnt    <= (r_cnt == CntLast) ? '0 : r_cnt + 6'd1;
      end
    end
  end

  assign valid_out   = r_v3;
  assign frame_last  = r_last;
  assign data_out_re = r_out_re;
  assign data_out_im = r_out_im;

endmodule

// File: tb/tb_twiddle_mult_2nd_ifft.sv
// Scoreboard bench for twiddle_mult_2nd_ifft: expectations are queued as samples are driven
// and popped as valid outputs appear.
module tb_twiddle_mult_2nd_ifft;

  localparam real Pi = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic signed [15:0] data_in_re = '0;
  logic signed [15:0] data_in_im = '0;
  logic [5:0]         Twiddle_address = '0;
  logic               valid_out;
  logic signed [15:0] data_out_re;
  logic signed [15:0] data_out_im;
  logic               frame_last;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               last;
  } exp_t;

  exp_t sb_q[$];
  int   sb_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  twiddle_mult_2nd_ifft #(
    .DATA_W (16),
    .TW_W   (16),
    .TW_STEP(8),
    .NFFT   (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in_re     (data_in_re),
    .data_in_im     (data_in_im),
    .Twiddle_address(Twiddle_address),
    .valid_out      (valid_out),
    .data_out_re    (data_out_re),
    .data_out_im    (data_out_im),
    .frame_last     (frame_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Golden model: twiddles from real trig, full-precision products, round, saturate.
  function automatic void model(input int are, input int aim, input int addr,
                                output int ore, output int oim);
    int     m, wre, wim;
    longint sr, si;
    m   = (addr * 8) % 64;
    wre = int'($floor(16384.0 * $cos(2.0 * Pi * real'(m) / 64.0) + 0.5));
    wim = int'($floor(16384.0 * $sin(2.0 * Pi * real'(m) / 64.0) + 0.5));
    sr  = longint'(are) * longint'(wre) - longint'(aim) * longint'(wim);
    si  = longint'(are) * longint'(wim) + longint'(aim) * longint'(wre);
    sr  = (sr + 64'sd8192) >>> 14;
    si  = (si + 64'sd8192) >>> 14;
    if (sr > 32767) sr = 32767; else if (sr < -32768) sr = -32768;
    if (si > 32767) si = 32767; else if (si < -32768) si = -32768;
    ore = int'(sr);
    oim = int'(si);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Drive one cycle; queue the expected output (explicit or modelled). Returns 1 after the edge.
  task automatic drive(input logic v, input int re, input int im, input int addr,
                       input logic fixed, input int ere, input int eim);
    exp_t e;
    int   mre, mim;
    valid_in        = v;
    data_in_re      = 16'(re);
    data_in_im      = 16'(im);
    Twiddle_address = 6'(addr);
    if (v && !rst) begin
      if (fixed) begin
        mre = ere;
        mim = eim;
      end else begin
        model(re, im, addr, mre, mim);
      end
      e.re   = 16'(mre);
      e.im   = 16'(mim);
      e.last = (sb_cnt == 63);
      sb_cnt = (sb_cnt + 1) % 64;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
    rst = 1'b0;
    sb_q.delete();
    sb_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b0;
      drive(c < 3, 1234, -567, 1, 1'b0, 0, 0);
      n_checks++;
      if (valid_out !== 1'b0 || frame_last !== 1'b0 || data_out_re !== 16'sd0 ||
          data_out_im !== 16'sd0)
        $display("FAIL reset_c%0d: got v=%b last=%b (%0d,%0d) expected v=0 last=0 (0,0)",
                 c, valid_out, frame_last, data_out_re, data_out_im);
      else n_pass++;
    end
    sb_q.delete();
    sb_cnt = 0;
  endtask

  task automatic test_identity_latency();
    exp_t e;
    drive(1'b1, 1234, -567, 0, 1'b1, 1234, -567);            // observe t+1
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0);                        // observe t+2
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL latency_t2: valid_out=%b expected 0", valid_out);
    else n_pass++;
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0);                        // observe t+3
    n_checks++;
    if (valid_out !== 1'b1 || sb_q.size() == 0) begin
      $display("FAIL latency_t3: valid_out=%b queued=%0d expected valid_out=1", valid_out,
               sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
        $display("FAIL identity: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                 data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
      else n_pass++;
    end
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0);                        // observe t+4
    n_checks++;
    if (valid_out !== 1'b0 || data_out_re !== 16'sd1234 || data_out_im !== -16'sd567)
      $display("FAIL latency_t4_hold: got v=%b (%0d,%0d) expected v=0 (1234,-567)",
               valid_out, data_out_re, data_out_im);
    else n_pass++;
  endtask

  task automatic test_rotation();
    int   a[4]  = '{2, 1, 9, 63};
    int   xr[4] = '{0, 707, 707, 707};
    int   xi[4] = '{1000, 707, 707, -707};
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive(1'b1, 1000, 0, a[c], 1'b1, xr[c], xi[c]);
      else       drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
      if (valid_out === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL rotation_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL rotation: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL rotation_drain: %0d outputs missing, expected 0",
                                   sb_q.size());
    else n_pass++;
  endtask

  task automatic test_saturation();
    int   a[3]  = '{1, 3, 1};
    int   dr[3] = '{-32768, 32767, 32767};
    int   di[3] = '{-32768, 32767, 32767};
    int   xr[3] = '{0, -32768, 0};
    int   xi[3] = '{-32768, 0, 32767};
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      if (c < 3) drive(1'b1, dr[c], di[c], a[c], 1'b1, xr[c], xi[c]);
      else       drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
      if (valid_out === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL sat_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL saturation: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sat_drain: %0d outputs missing, expected 0",
                                   sb_q.size());
    else n_pass++;
  endtask

  // Every address value, random data, no gaps.
  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 80 && (c < 64 || sb_q.size() > 0); c++) begin
      if (c < 64) drive(1'b1, rnd(), rnd(), c, 1'b0, 0, 0);
      else        drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
      if (valid_out === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL b2b_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL b2b: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL b2b_drain: %0d outputs missing, expected 0",
                                   sb_q.size());
    else n_pass++;
  endtask

  // One aligned frame with bubbles, then part of the next frame to show the wrap.
  task automatic test_stream();
    exp_t e;
    int   i = 0, bubbles = 0, n_out = 0, n_last = 0, last_idx = 0;
    logic bub;
    apply_reset(2);
    for (int c = 0; c < 120 && (i < 72 || sb_q.size() > 0); c++) begin
      bub = (i == 13 || i == 26 || i == 32 || i == 41 || i == 51) && bubbles < 5 &&
            !(bubbles == 0 && i != 13);
      if (i < 72 && !bub) begin
        drive(1'b1, rnd(), rnd(), i[0] ? int'({i[1], i[2]}) : 0, 1'b0, 0, 0);
        i++;
      end else begin
        if (bub) bubbles++;
        drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
      end
      if (valid_out === 1'b1) begin
        n_out++;
        if (frame_last === 1'b1) begin
          n_last++;
          last_idx = n_out;
        end
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL stream_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL stream: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (n_out != 72 || n_last != 1 || last_idx != 64)
      $display("FAIL stream_frame: outputs=%0d pulses=%0d at=%0d expected 72 1 64",
               n_out, n_last, last_idx);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n_out = 0, i = 0, first_last = 0;
    apply_reset(2);
    for (int c = 0; c < 40 && n_out < 20; c++) begin
      drive(1'b1, rnd(), rnd(), c % 4, 1'b0, 0, 0);
      if (valid_out === 1'b1) begin
        n_out++;
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL midrst_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL midrst_pre: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (n_out != 20) $display("FAIL midrst_count: outputs=%0d expected 20", n_out);
    else n_pass++;
    rst = 1'b1;
    drive(1'b1, 5, 5, 0, 1'b0, 0, 0);
    drive(1'b1, 5, 5, 0, 1'b0, 0, 0);
    rst = 1'b0;
    sb_q.delete();
    sb_cnt = 0;
    n_out = 0;
    for (int c = 0; c < 90 && (i < 66 || sb_q.size() > 0); c++) begin
      if (i < 66) begin
        drive(1'b1, rnd(), rnd(), i % 8, 1'b0, 0, 0);
        i++;
      end else begin
        drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
      end
      if (c < 2) begin
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL midrst_flush: valid_out=%b expected 0",
                                         valid_out);
        else n_pass++;
      end
      if (valid_out === 1'b1) begin
        n_out++;
        if (frame_last === 1'b1 && first_last == 0) first_last = n_out;
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL midrst_extra: valid_out=1 with nothing queued");
        else begin
          e = sb_q.pop_front();
          if (data_out_re !== e.re || data_out_im !== e.im || frame_last !== e.last)
            $display("FAIL midrst_post: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                     data_out_re, data_out_im, frame_last, e.re, e.im, e.last);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (first_last != 64 || n_out != 66)
      $display("FAIL midrst_frame: first frame_last at %0d of %0d, expected 64 of 66",
               first_last, n_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_identity_latency();
    test_rotation();
    test_saturation();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
